// File: rtl/multicycle_control_unit.sv
// Main control FSM of a multicycle MIPS-style CPU: a Moore state register plus
// decoded datapath controls, with write strobes masked while reset is high.
module multicycle_control_unit #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_J     = 6'b000010,
    parameter logic [5:0] OP_ADDI  = 6'b001000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic       Zero,
    output logic       PCWrite,
    output logic [1:0] PCSource,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXECUTE   = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        ADDI_EXEC = 4'd10,
        ADDI_WB   = 4'd11
    } state_e;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_SUB    = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

    state_e state_q;
    state_e state_d;

    // Unmasked write strobes; the reset mask is applied on the way out.
    logic pc_write_raw;
    logic mem_write_raw;
    logic ir_write_raw;
    logic reg_write_raw;

    always_comb begin
        // NOTE: default assigned before the case so no path leaves state_d
        // unassigned; without it the tool would infer a latch.
        state_d = FETCH;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                case (Op)
                    OP_LW, OP_SW: state_d = MEM_ADDR;
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
                    OP_J:         state_d = JUMP;
                    OP_ADDI:      state_d = ADDI_EXEC;
                    default:      state_d = FETCH;
                endcase
            end
            MEM_ADDR: begin
                if (Op == OP_SW) begin
                    state_d = MEM_WRITE;
                end else if (Op == OP_LW) begin
                    state_d = MEM_READ;
                end else begin
                    state_d = FETCH;
                end
            end
            MEM_READ:  state_d = MEM_WB;
            EXECUTE:   state_d = R_WB;
            ADDI_EXEC: state_d = ADDI_WB;
            default:   state_d = FETCH;
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignment so every flop
        // samples its input from before the edge, independent of block order.
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Moore decode; only BRANCH looks at an input (Zero) to gate PCWrite.
    always_comb begin
        pc_write_raw  = 1'b0;
        PCSource      = PCSRC_ALU;
        IorD          = 1'b0;
        MemRead       = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        MemtoReg      = 1'b0;
        RegDst        = 1'b0;
        reg_write_raw = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = SRCB_REG;
        ALUOp         = ALUOP_ADD;
        case (state_q)
            FETCH: begin
                MemRead      = 1'b1;
                ir_write_raw = 1'b1;
                pc_write_raw = 1'b1;
                ALUSrcB      = SRCB_FOUR;
            end
            DECODE: begin
                ALUSrcB = SRCB_IMM_SH2;
            end
            MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            MEM_WB: begin
                reg_write_raw = 1'b1;
                MemtoReg      = 1'b1;
            end
            MEM_WRITE: begin
                mem_write_raw = 1'b1;
                IorD          = 1'b1;
            end
            EXECUTE: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_FUNCT;
            end
            R_WB: begin
                reg_write_raw = 1'b1;
                RegDst        = 1'b1;
            end
            BRANCH: begin
                ALUSrcA      = 1'b1;
                ALUOp        = ALUOP_SUB;
                PCSource     = PCSRC_ALUOUT;
                pc_write_raw = Zero;
            end
            JUMP: begin
                PCSource     = PCSRC_JUMP;
                pc_write_raw = 1'b1;
            end
            ADDI_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            ADDI_WB: begin
                reg_write_raw = 1'b1;
            end
            default: ;
        endcase
    end

    // Combinational mask: no architectural write escapes while reset is held,
    // even in the cycle reset first rises mid-instruction.
    assign PCWrite  = pc_write_raw  & ~reset;
    assign MemWrite = mem_write_raw & ~reset;
    assign IRWrite  = ir_write_raw  & ~reset;
    assign RegWrite = reg_write_raw & ~reset;
    assign State    = state_q;

endmodule
